// File: rtl/rca_word_sequencer.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple-carry slice reused over WIDTH/4 passes,
// LSB nibble first, with the carry chained through a register between passes.

module ripple_carry_adder (
  input  logic [8:0] sw,
  output logic [4:0] ledr
);
  logic [4:0] c;

  always_comb begin
    c       = '0;
    ledr    = '0;
    c[0]    = sw[8];
    for (int i = 0; i < 4; i++) begin
      ledr[i]  = sw[4+i] ^ sw[i] ^ c[i];
      c[i+1]   = (sw[4+i] & sw[i]) | (c[i] & (sw[4+i] ^ sw[i]));
    end
    ledr[4] = c[4];
  end
endmodule

module rca_word_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             carry_p0;
  logic [KW+1:0]    lo;
  logic [8:0]       sw;
  logic [4:0]       ledr;

  // Nibble k of the latched operands feeds the shared slice.
  always_comb begin
    lo = {k, 2'b00};
    sw = {carry_p0, a_p0[lo +: 4], b_p0[lo +: 4]};
  end

  ripple_carry_adder u_slice (
    .sw   (sw),
    .ledr (ledr)
  );

  // Overflow uses the MSB of the final nibble written on the last pass.
  function automatic logic ovf_of(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      a_p0     <= '0;
      b_p0     <= '0;
      carry_p0 <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_p0     <= a;
            b_p0     <= b;
            carry_p0 <= ci;
            k        <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[lo +: 4] <= ledr[3:0];
          carry_p0     <= ledr[4];
          if (k == K_LAST) begin
            cout  <= ledr[4];
            ovf   <= ovf_of(a_p0[WIDTH-1], b_p0[WIDTH-1], ledr[3]);
            state <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule
